shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, pipelined barrel shifter/rotator for the WISC datapath. It generalises the fixed 16-bit, single-distance rotate stage into a WIDTH-bit unit with four modes and a full log2(WIDTH)-bit shift amount. The unit is a log2(WIDTH)-deep register pipeline with valid/ready flow control, and sits between the decode/operand-read stage and the ALU writeback mux.

## Interface
- WIDTH, 16: data width; must be a power of two, at least 4.
- STAGES, $clog2(WIDTH): derived, not overridable; number of pipeline stages.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operand valid.
- in_ready  out  1  unit can accept this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  STAGES  shift/rotate distance, 0..WIDTH-1.
- in_op  in  2  operation: 00 ROL, 01 SLL, 10 ROR, 11 SRA.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_zero  out  1  result is all zeros (only when SHIFT_ZFLAG_EN is defined).

## Operation
- Stage k (k = 0..STAGES-1) applies a distance of 2^k when amt[k]=1; otherwise it passes data through.
- op and amt travel with the data through every stage.
- ROL: bits leaving the MSB re-enter at the LSB.
- SLL: zeros fill from the LSB.
- ROR: bits leaving the LSB re-enter at the MSB.
- SRA: the original operand MSB (carried in the pipe) fills from the MSB.
- Amount 0 returns the operand unchanged for every op.
- Each stage has a valid bit. Stage k loads when it is empty, or when stage k+1 loads, or (for the last stage) when out_ready=1.
- in_ready = stage 0 loads this cycle. Bubbles collapse, so an empty stage accepts even when a later stage is stalled.
- Capacity: STAGES results in flight. Results leave in acceptance order; none are dropped or duplicated.
- out_valid = last-stage valid; out_data = last-stage data.
- While out_valid=1 and out_ready=0, out_data (and out_zero) hold stable.
- A transfer occurs on an edge where valid&ready=1 on that side.
- Reset (rst_n=0 on a rising edge) clears every stage valid bit and zeroes every stage data/op/amt register. Any operations in flight are discarded.
- Reset values of outputs: out_valid=0, out_data=0, out_zero=1 (when present), in_ready=1.

## Timing
- Latency: an operand accepted on edge t makes out_valid=1 from edge t+STAGES-1. For WIDTH=16, that is 3 edges after the accepting edge.
- Throughput: one result per cycle while out_ready=1.
- in_ready depends combinationally on out_ready through the stall chain. in_ready does not depend on in_valid.
- Simultaneous accept and emit with a full pipe: allowed, and occupancy is unchanged.
- The first edge with rst_n=1 after reset may accept an operand.

## Configuration
- SHIFT_ZFLAG_EN defined: out_zero exists and is registered in the last stage alongside out_data, equal to (result == 0). It has the same valid/hold semantics as out_data.
- SHIFT_ZFLAG_EN undefined: the out_zero port and its register are absent; all other behaviour is identical.

## Structure
- Package shift_pkg holds the op encodings (SHIFT_ROL=2'b00, SHIFT_SLL=2'b01, SHIFT_ROR=2'b10, SHIFT_SRA=2'b11) and a stage payload typedef (data, op, amt, sign bit).
- Sub-module shift_stage, parametrised by WIDTH and DIST:
  - one conditional 2^k shift/rotate mux for all four ops;
  - the payload register and valid bit, with load/reset control.
- shift_pipe instantiates STAGES copies of shift_stage and the ready chain.

## Test plan
- ROL 0x8001 by 1, out_ready=1 -> 0x0003, 3 edges after accept. ROR 0x1234 by 4 -> 0x4123.
- SRA 0x8000 by 15 -> 0xFFFF. SRA 0x4000 by 14 -> 0x0001. SLL 0x0001 by 15 -> 0x8000. Amount 0 on 0xA5A5 for all four ops -> 0xA5A5.
- Stall test: hold out_ready=0 and present 6 back-to-back operands (SLL 0x0001 by 0..5). Exactly 4 are accepted and in_ready falls. Then raise out_ready: outputs are 0x0001, 0x0002, 0x0004, 0x0008 in that order, then the remaining 2 are accepted and returned as 0x0010, 0x0020.
- Bubble collapse: a single operand is in flight with out_ready=0 and the other stages are empty. in_ready stays 1 until 4 operands are held.
- Reset mid-stream: pull rst_n low for one edge with 3 operands in flight. Afterwards out_valid=0, out_data=0, and no stale result is ever emitted. The next accepted operand completes normally.
- SHIFT_ZFLAG_EN build: SLL 0x8000 by 1 -> out_data=0x0000, out_zero=1. ROL 0x8000 by 1 -> 0x0001, out_zero=0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift_pipe barrel shifter/rotator.
// Operation encodings and the control part of the per-stage payload.
package shift_pkg;

   typedef enum logic [1:0] {
      SHIFT_ROL = 2'b00,
      SHIFT_SLL = 2'b01,
      SHIFT_ROR = 2'b10,
      SHIFT_SRA = 2'b11
   } shift_op_e;

   // Control fields carried with the data; sign is the original operand MSB.
   // Data and amount widths depend on the instance, so those travel beside it.
   typedef struct packed {
      shift_op_e op;
      logic      sign;
   } shift_ctl_t;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditional shift/rotate by DIST and the payload register.
// Optional SHIFT_ZFLAG_EN adds a registered result-is-zero flag.
module shift_stage
   import shift_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIST  = 1,
   parameter int AMT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [AMT_W-1:0]   in_amt,
   input  shift_ctl_t         in_ctl,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [AMT_W-1:0]   out_amt,
`ifdef SHIFT_ZFLAG_EN
   output logic               out_zero,
`endif
   output shift_ctl_t         out_ctl
);

   localparam int BIT = $clog2(DIST);

   logic [WIDTH-1:0] shifted;

   always_comb begin
      shifted = in_data;
      if (in_amt[BIT]) begin
         case (in_ctl.op)
            SHIFT_ROL: shifted = {in_data[WIDTH-DIST-1:0], in_data[WIDTH-1:WIDTH-DIST]};
            SHIFT_SLL: shifted = {in_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
            SHIFT_ROR: shifted = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
            SHIFT_SRA: shifted = {{DIST{in_ctl.sign}}, in_data[WIDTH-1:DIST]};
            default:   shifted = in_data;
         endcase
      end
   end

   // Payload only captures real operands so a stalled or idle output stays put.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_amt   <= '0;
         out_ctl   <= '0;
      end else if (load) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= shifted;
            out_amt  <= in_amt;
            out_ctl  <= in_ctl;
         end
      end
   end

`ifdef SHIFT_ZFLAG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_zero <= 1'b1;
      end else if (load && in_valid) begin
         out_zero <= (shifted == '0);
      end
   end
`endif

endmodule

// File: rtl/shift_pipe.sv
// Pipelined WIDTH-bit barrel shifter/rotator with valid/ready flow control.
// Define SHIFT_ZFLAG_EN to add the registered out_zero result flag.
module shift_pipe
   import shift_pkg::*;
#(
   parameter  int WIDTH  = 16,
   localparam int STAGES = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [STAGES-1:0] in_amt,
   input  logic [1:0]        in_op,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef SHIFT_ZFLAG_EN
   output logic              out_zero,
`endif
   output logic [WIDTH-1:0]  out_data
);

   // Index 0 is the input side; index k+1 is the register of stage k.
   logic [STAGES:0]   vld;
   logic [STAGES:0]   ld;
   logic [WIDTH-1:0]  dat [STAGES+1];
   logic [STAGES-1:0] amt [STAGES+1];
   shift_ctl_t        ctl [STAGES+1];
`ifdef SHIFT_ZFLAG_EN
   logic              zf  [STAGES];
`endif

   assign vld[0] = in_valid;
   assign dat[0] = in_data;
   assign amt[0] = in_amt;
   assign ctl[0] = '{op: shift_op_e'(in_op), sign: in_data[WIDTH-1]};

   // Stall chain: a stage loads when empty or when its successor loads,
   // so bubbles collapse even while the output is blocked.
   always_comb begin
      ld         = '0;
      ld[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         ld[k] = ~vld[k+1] | ld[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << k),
         .AMT_W (STAGES)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (ld[k]),
         .in_valid  (vld[k]),
         .in_data   (dat[k]),
         .in_amt    (amt[k]),
         .in_ctl    (ctl[k]),
         .out_valid (vld[k+1]),
         .out_data  (dat[k+1]),
         .out_amt   (amt[k+1]),
`ifdef SHIFT_ZFLAG_EN
         .out_zero  (zf[k]),
`endif
         .out_ctl   (ctl[k+1])
      );
   end

   assign in_ready  = ld[0];
   assign out_valid = vld[STAGES];
   assign out_data  = dat[STAGES];
`ifdef SHIFT_ZFLAG_EN
   assign out_zero  = zf[STAGES-1];
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe (WIDTH=16): driver pushes expected results
// on acceptance, a negedge monitor pops and compares every emitted result.
module tb_shift_pipe;
   import shift_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_amt;
   logic [1:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
`ifdef SHIFT_ZFLAG_EN
   logic        out_zero;
`endif

   shift_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef SHIFT_ZFLAG_EN
      .out_zero  (out_zero),
`endif
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        zero;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   pushed = 0;
   int   popped = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void push(logic [15:0] e, bit lat);
      exp_t x;
      x.data = e;
      x.zero = (e == 16'h0000);
      x.acc  = cyc;
      x.lat  = lat;
      sb.push_back(x);
      pushed++;
   endfunction

   // Monitor: outputs and out_ready are stable at the falling edge.
   bit          hold_prev = 0;
   logic [15:0] hold_data;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         hold_prev = 0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), int'(hold_data));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_result", int'(out_data), -1);
            end else begin
               e = sb.pop_front();
               popped++;
               check("result_data", int'(out_data), int'(e.data));
`ifdef SHIFT_ZFLAG_EN
               check("result_zero", int'(out_zero), int'(e.zero));
`endif
               if (e.lat) check("latency_edges", cyc - (e.acc + 1), 3);
            end
         end
         hold_prev = out_valid && !out_ready;
         hold_data = out_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [3:0] amt,
                       input logic [15:0] d, input logic [15:0] e, input bit lat);
      bit done = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_amt   = amt;
      in_data  = d;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            push(e, lat);
            done = 1;
         end
         step();
      end
      in_valid = 1'b0;
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic drain();
      int c = 0;
      while ((sb.size() != 0 || out_valid) && c < 60) begin
         step();
         c++;
      end
      if (c >= 60) check("drain_timeout", sb.size(), 0);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  amt;
      logic [15:0] d;
      logic [15:0] e;
   } vec_t;

   vec_t vecs[$] = '{
      '{SHIFT_ROL, 4'd1,  16'h8001, 16'h0003},
      '{SHIFT_ROR, 4'd4,  16'h1234, 16'h4123},
      '{SHIFT_SRA, 4'd15, 16'h8000, 16'hFFFF},
      '{SHIFT_SRA, 4'd14, 16'h4000, 16'h0001},
      '{SHIFT_SLL, 4'd15, 16'h0001, 16'h8000},
      '{SHIFT_ROL, 4'd0,  16'hA5A5, 16'hA5A5},
      '{SHIFT_SLL, 4'd0,  16'hA5A5, 16'hA5A5},
      '{SHIFT_ROR, 4'd0,  16'hA5A5, 16'hA5A5},
      '{SHIFT_SRA, 4'd0,  16'hA5A5, 16'hA5A5},
      '{SHIFT_SLL, 4'd1,  16'h8000, 16'h0000},
      '{SHIFT_ROL, 4'd1,  16'h8000, 16'h0001},
      '{SHIFT_SRA, 4'd3,  16'hB000, 16'hF600},
      '{SHIFT_ROR, 4'd15, 16'h0001, 16'h0002},
      '{SHIFT_ROL, 4'd8,  16'h1234, 16'h3412},
      '{SHIFT_SLL, 4'd4,  16'hABCD, 16'hBCD0}
   };

   initial begin
      int  n_acc;
      int  idx;
      bit  got;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_op     = '0;
      out_ready = 1'b0;
      step();
      step();
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_data", int'(out_data), 0);
      check("reset_in_ready", int'(in_ready), 1);
`ifdef SHIFT_ZFLAG_EN
      check("reset_out_zero", int'(out_zero), 1);
`endif
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // Directed vectors, back-to-back with the consumer always ready.
      foreach (vecs[i]) send(vecs[i].op, vecs[i].amt, vecs[i].d, vecs[i].e, 1'b1);
      drain();

      // Stall: six SLL operands against a blocked consumer.
      out_ready = 1'b0;
      n_acc     = 0;
      idx       = 0;
      in_valid  = 1'b1;
      in_op     = SHIFT_SLL;
      in_amt    = 4'd0;
      in_data   = 16'h0001;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         got = in_ready;
         if (got) begin
            push(16'h0001 << idx, 1'b0);
            n_acc++;
         end
         step();
         if (got && idx < 5) begin
            idx++;
            in_amt = 4'(idx);
         end
      end
      check("stall_accepted", n_acc, 4);
      check("stall_in_ready", int'(in_ready), 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = idx; i < 6; i++) send(SHIFT_SLL, 4'(i), 16'h0001, 16'h0001 << i, 1'b0);
      drain();

      // Bubble collapse: one operand parked at the output, three more still fit.
      out_ready = 1'b0;
      send(SHIFT_ROL, 4'd4, 16'h000F, 16'h00F0, 1'b0);
      repeat (6) step();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_op    = SHIFT_ROR;
         in_amt   = 4'(i + 1);
         in_data  = 16'h0100;
         @(negedge clk);
         check("bubble_in_ready", int'(in_ready), 1);
         if (in_ready) push(16'h0100 >> (i + 1), 1'b0);
         step();
      end
      in_valid = 1'b1;
      in_op    = SHIFT_SLL;
      in_amt   = 4'd2;
      in_data  = 16'h0101;
      @(negedge clk);
      check("bubble_full_in_ready", int'(in_ready), 0);
      step();
      out_ready = 1'b1;
      send(SHIFT_SLL, 4'd2, 16'h0101, 16'h0404, 1'b0);
      drain();

      // Reset with three operands in flight; nothing stale may appear afterwards.
      out_ready = 1'b0;
      send(SHIFT_SLL, 4'd1, 16'h1111, 16'h2222, 1'b0);
      send(SHIFT_SLL, 4'd2, 16'h1111, 16'h4444, 1'b0);
      send(SHIFT_SLL, 4'd3, 16'h1111, 16'h8888, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      sb.delete();
      pushed -= 3;
      check("midreset_out_valid", int'(out_valid), 0);
      check("midreset_out_data", int'(out_data), 0);
      check("midreset_in_ready", int'(in_ready), 1);
      out_ready = 1'b1;
      repeat (8) step();
      send(SHIFT_ROR, 4'd4, 16'h1234, 16'h4123, 1'b1);
      drain();

      check("results_count", popped, pushed);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule
